// File: rtl/somador_serial_if.sv
// rtl/somador_serial_if.sv - operand/result bundle for the serial adder
interface somador_serial_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, s, cout, ovf
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, s, cout, ovf
   );
endinterface

// File: rtl/somador_serial.sv
// rtl/somador_serial.sv - bit-serial adder/subtractor, LSB first, one bit per clock
module somador_serial #(
   parameter int  WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic             clk,
   input logic             rst,
   somador_serial_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             sum_bit;
   logic             carry_nx;
   logic [WIDTH-1:0] res_nx;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      // the single full-adder cell, fed by the operand LSBs
      sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
      carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
      res_nx   = res_q >> 1;
      res_nx[WIDTH-1] = sum_bit;

      case (state_q)
         ST_RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = res_nx;
            carry_d = carry_nx;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               // carry_q is the carry into the MSB on this last step
               s_d     = res_nx;
               cout_d  = carry_nx;
               ovf_d   = carry_q ^ carry_nx;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (bus.start && (state_q != ST_RUN)) begin
         a_d     = bus.a;
         b_d     = bus.sub ? ~bus.b : bus.b;
         carry_d = bus.sub ? 1'b1 : bus.cin;
         cnt_d   = '0;
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = (state_q == ST_DONE);
   assign bus.s    = s_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_somador_serial.sv
// tb/tb_somador_serial.sv - randomized and directed bench for somador_serial (WIDTH 8 and 1)
module tb_somador_serial;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   somador_serial_if #(.WIDTH(8)) if8 ();
   somador_serial_if #(.WIDTH(1)) if1 ();

   somador_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
   somador_serial #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   int         m_left [2] = '{0, 0};
   logic       m_done [2];
   logic [7:0] m_s    [2];
   logic       m_cout [2];
   logic       m_ovf  [2];
   logic [9:0] p_res  [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // {ovf, cout, s} from plain integer arithmetic on w-bit operands
   function automatic logic [9:0] ref_op(input int w, input logic sub, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
      int mask, half, ua, ub, c, sum, sa, sb, ss;
      logic [9:0] r;
      mask = (1 << w) - 1;
      half = 1 << (w - 1);
      ua   = int'(a) & mask;
      ub   = sub ? ((int'(b) ^ mask) & mask) : (int'(b) & mask);
      c    = sub ? 1 : int'(cin);
      sum  = ua + ub + c;
      sa   = (ua >= half) ? ua - 2 * half : ua;
      sb   = (ub >= half) ? ub - 2 * half : ub;
      ss   = sa + sb + c;
      r[7:0] = 8'(sum & mask);
      r[8]   = ((sum >> w) & 1) != 0;
      r[9]   = (ss > half - 1) || (ss < -half);
      return r;
   endfunction

   task automatic drive(input int k, input logic st, input logic sb, input logic [7:0] a,
                        input logic [7:0] b, input logic ci);
      if (k == 0) begin
         if8.start = st; if8.sub = sb; if8.a = a; if8.b = b; if8.cin = ci;
      end else begin
         if1.start = st; if1.sub = sb; if1.a = a[0]; if1.b = b[0]; if1.cin = ci;
      end
   endtask

   // reference: an accepted request keeps the block busy for w cycles, then one done cycle
   always @(posedge clk) begin : model
      int         w;
      logic       nd, st, sb, ci;
      logic [7:0] av, bv;
      for (int k = 0; k < 2; k++) begin
         w  = (k == 0) ? 8 : 1;
         st = (k == 0) ? if8.start : if1.start;
         sb = (k == 0) ? if8.sub : if1.sub;
         ci = (k == 0) ? if8.cin : if1.cin;
         av = (k == 0) ? if8.a : {7'b0, if1.a};
         bv = (k == 0) ? if8.b : {7'b0, if1.b};
         if (rst) begin
            m_left[k] = 0; m_done[k] = 1'b0; m_s[k] = 8'h00; m_cout[k] = 1'b0; m_ovf[k] = 1'b0;
         end else begin
            nd = 1'b0;
            if (m_left[k] > 0) begin
               m_left[k]--;
               if (m_left[k] == 0) begin
                  nd = 1'b1;
                  m_s[k] = p_res[k][7:0]; m_cout[k] = p_res[k][8]; m_ovf[k] = p_res[k][9];
               end
            end else if (st) begin
               m_left[k] = w;
               p_res[k]  = ref_op(w, sb, av, bv, ci);
            end
            m_done[k] = nd;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("w8_busy", 32'(if8.busy), 32'(m_left[0] > 0));
         chk("w8_done", 32'(if8.done), 32'(m_done[0]));
         chk("w8_s",    32'(if8.s),    32'(m_s[0]));
         chk("w8_cout", 32'(if8.cout), 32'(m_cout[0]));
         chk("w8_ovf",  32'(if8.ovf),  32'(m_ovf[0]));
         chk("w1_busy", 32'(if1.busy), 32'(m_left[1] > 0));
         chk("w1_done", 32'(if1.done), 32'(m_done[1]));
         chk("w1_s",    32'(if1.s),    32'(m_s[1][0]));
         chk("w1_cout", 32'(if1.cout), 32'(m_cout[1]));
         chk("w1_ovf",  32'(if1.ovf),  32'(m_ovf[1]));
      end
   end

   task automatic run_op(input int k, input logic sb, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input bit glitch,
                         output logic [7:0] rs, output logic rc, output logic ro);
      int n;
      int w;
      bit seen;
      w = (k == 0) ? 8 : 1;
      drive(k, 1'b1, sb, a, b, ci);
      @(posedge clk);
      #2;
      drive(k, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (glitch && n == 3) drive(k, 1'b1, ~sb, 8'($urandom), 8'($urandom), ~ci);
         if (glitch && n == 4) drive(k, 1'b0, sb, a, b, ci);
         seen = (k == 0) ? if8.done : if1.done;
      end
      chk($sformatf("latency_k%0d", k), 32'(n), 32'(w + 1));
      rs = (k == 0) ? if8.s : {7'b0, if1.s};
      rc = (k == 0) ? if8.cout : if1.cout;
      ro = (k == 0) ? if8.ovf : if1.ovf;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rs;
      logic       rc, ro;
      logic [9:0] e;
      logic [7:0] ra, rb;
      logic       rsub, rci;
      logic [2:0] v;
      logic [1:0] fa_tab [8];
      fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

      rst = 1'b1;
      drive(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      drive(1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy", 32'(if8.busy), 0);
      chk("rst_done", 32'(if8.done), 0);
      chk("rst_s",    32'(if8.s),    32'h00);
      chk("rst_cout", 32'(if8.cout), 0);
      chk("rst_ovf",  32'(if8.ovf),  0);
      repeat (3) @(negedge clk);
      chk("idle_busy", 32'(if8.busy), 0);
      chk("idle_done", 32'(if8.done), 0);

      chk("model_add",  32'(ref_op(8, 1'b0, 8'h3C, 8'h0F, 1'b0)), 32'h04B);
      chk("model_addc", 32'(ref_op(8, 1'b0, 8'hFF, 8'h01, 1'b1)), 32'h101);
      chk("model_sub1", 32'(ref_op(8, 1'b1, 8'h50, 8'hB0, 1'b0)), 32'h2A0);
      chk("model_sub2", 32'(ref_op(8, 1'b1, 8'h05, 8'h03, 1'b0)), 32'h102);

      run_op(0, 1'b0, 8'h3C, 8'h0F, 1'b0, 1'b0, rs, rc, ro);
      chk("add_3c_s", 32'(rs), 32'h4B); chk("add_3c_cout", 32'(rc), 0); chk("add_3c_ovf", 32'(ro), 0);
      run_op(0, 1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, rs, rc, ro);
      chk("add_ff_s", 32'(rs), 32'h01); chk("add_ff_cout", 32'(rc), 1); chk("add_ff_ovf", 32'(ro), 0);
      run_op(0, 1'b1, 8'h50, 8'hB0, 1'b0, 1'b0, rs, rc, ro);
      chk("sub_50_s", 32'(rs), 32'hA0); chk("sub_50_cout", 32'(rc), 0); chk("sub_50_ovf", 32'(ro), 1);
      run_op(0, 1'b1, 8'h05, 8'h03, 1'b0, 1'b0, rs, rc, ro);
      chk("sub_05_s", 32'(rs), 32'h02); chk("sub_05_cout", 32'(rc), 1); chk("sub_05_ovf", 32'(ro), 0);
      // issued from the done cycle of the previous op: no idle gap
      run_op(0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, rs, rc, ro);
      chk("b2b_s", 32'(rs), 32'h02);

      repeat (2) @(negedge clk);
      run_op(0, 1'b0, 8'h12, 8'h34, 1'b0, 1'b1, rs, rc, ro);
      chk("glitch_s", 32'(rs), 32'h46); chk("glitch_cout", 32'(rc), 0);

      drive(0, 1'b1, 1'b0, 8'h77, 8'h11, 1'b0);
      @(posedge clk);
      #2;
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(if8.busy), 0);
      chk("midrst_s",    32'(if8.s),    32'h00);
      chk("midrst_done", 32'(if8.done), 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("midrst_nodone", 32'(if8.done), 0);
      end
      run_op(0, 1'b0, 8'h20, 8'h22, 1'b1, 1'b0, rs, rc, ro);
      chk("after_rst_s", 32'(rs), 32'h43);

      for (int i = 0; i < 40; i++) begin
         rsub = 1'($urandom); rci = 1'($urandom);
         ra = 8'($urandom); rb = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(0, rsub, ra, rb, rci, 1'b0, rs, rc, ro);
         e = ref_op(8, rsub, ra, rb, rci);
         chk("rand_res", {22'b0, ro, rc, rs}, 32'(e));
      end

      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         repeat (1) @(negedge clk);
         run_op(1, 1'b0, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 1'b0, rs, rc, ro);
         chk($sformatf("fa_s_%0d", i),    32'(rs[0]), 32'(fa_tab[i][0]));
         chk($sformatf("fa_cout_%0d", i), 32'(rc),    32'(fa_tab[i][1]));
      end
      for (int i = 0; i < 4; i++) begin
         v = 3'(i);
         run_op(1, 1'b1, {7'b0, v[1]}, {7'b0, v[0]}, 1'b0, 1'b0, rs, rc, ro);
         e = ref_op(1, 1'b1, {7'b0, v[1]}, {7'b0, v[0]}, 1'b0);
         chk($sformatf("w1_sub_%0d", i), {22'b0, ro, rc, 7'b0, rs[0]}, 32'(e));
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
